// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
//   Multi-cycle signed multiply/divide unit for the execute stage. A start
//   pulse latches the operands, the unit iterates, then presents the result
//   for exactly one cycle in DONE with data_resultRDY high. The stall logic
//   holds the pipeline while busy is high. abort (branch flush) cancels an
//   in-flight op without a ready pulse.
//
//   Multiply: radix-4 Booth, WIDTH/2 iterations, full 2*WIDTH product.
//   Divide  : non-restoring on magnitudes, WIDTH iterations, sign fix-up at
//             the end, quotient truncated toward zero.
//
// Parameters
//   WIDTH           operand/result width; must be even and >= 4
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high; clears all state
//   ctrl_MULT       start signed multiply (wins if ctrl_DIV is also high)
//   ctrl_DIV        start signed divide
//   abort           cancel in-flight op; outranks everything but reset
//   data_operandA   multiplicand / dividend, latched on the start edge
//   data_operandB   multiplier / divisor, latched on the start edge
//   data_result     product low WIDTH bits / quotient, held until next DONE
//   data_exception  product overflow, divide-by-zero or MIN/-1
//   data_resultRDY  one-cycle pulse while the result is fresh
//   busy            high in MUL, DIV and DONE
// ---------------------------------------------------------------------------
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;  // holds WIDTH without wrapping
  localparam int PW = 2 * WIDTH;          // full product width
  localparam int RW = WIDTH + 2;          // partial remainder spans +/-2*divisor

  localparam logic [CW-1:0]    C_HALF = CW'(WIDTH / 2);
  localparam logic [CW-1:0]    C_FULL = CW'(WIDTH);
  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;

  // Multiply datapath: multiplicand is sign-extended and shifted left two
  // places per iteration so each Booth digit lands at its own weight.
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_prev;
  logic [PW-1:0]    r_acc;

  // Divide datapath: r_quo starts as the dividend magnitude and shifts its
  // bits into the remainder while quotient bits shift in from the right.
  logic [RW-1:0]    r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg_q;
  logic             r_div_ovf;

  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_next;
  logic             w_mul_ovf;
  logic [RW-1:0]    w_dvsr_ext;
  logic [RW-1:0]    w_rem_shift;
  logic [RW-1:0]    w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  // Booth radix-4 digit selection from {b[2i+1], b[2i], b[2i-1]}.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pp = '0;
    case ({r_mplier[1:0], r_prev})
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = -(r_mcand << 1);
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  // Overflow when the upper half plus the low-half sign bit are not all equal.
  assign w_mul_ovf = (r_acc[PW-1:WIDTH-1] != {(WIDTH+1){r_acc[WIDTH-1]}});

  // Non-restoring step: subtract while the remainder is non-negative,
  // add back otherwise; quotient bit is 1 when the new remainder is >= 0.
  assign w_dvsr_ext   = {2'b00, r_dvsr};
  assign w_rem_shift  = {r_rem[RW-2:0], r_quo[WIDTH-1]};
  assign w_rem_next   = r_rem[RW-1] ? (w_rem_shift + w_dvsr_ext)
                                    : (w_rem_shift - w_dvsr_ext);
  assign w_quo_next   = {r_quo[WIDTH-2:0], ~w_rem_next[RW-1]};
  assign w_quo_signed = r_neg_q ? -r_quo : r_quo;

  // Magnitudes; MIN maps onto itself, which is 2^(WIDTH-1) read unsigned.
  assign w_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // NOTE: asynchronous reset sits in the sensitivity list so outputs clear
  // immediately, even mid-operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prev    <= 1'b0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_neg_q   <= 1'b0;
      r_div_ovf <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      r_rdy <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_cnt <= '0;
            if (ctrl_MULT) begin
              r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
              r_mplier <= data_operandB;
              r_prev   <= 1'b0;
              r_acc    <= '0;
              r_state  <= S_MUL;
              r_busy   <= 1'b1;
            end else if (ctrl_DIV) begin
              r_rem     <= '0;
              r_quo     <= w_a_mag;
              r_dvsr    <= w_b_mag;
              r_neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              r_div_ovf <= (data_operandA == C_MIN) && (data_operandB == '1);
              r_state   <= S_DIV;
              r_busy    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          S_MUL: begin
            if (r_cnt == C_HALF) begin
              r_result <= r_acc[WIDTH-1:0];
              r_exc    <= w_mul_ovf;
              r_rdy    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc    <= w_acc_next;
              r_mcand  <= r_mcand << 2;
              r_mplier <= {{2{r_mplier[WIDTH-1]}}, r_mplier[WIDTH-1:2]};
              r_prev   <= r_mplier[1];
              r_cnt    <= r_cnt + CW'(1);
            end
          end

          S_DIV: begin
            if (r_dvsr == '0) begin
              r_result <= '0;
              r_exc    <= 1'b1;
              r_rdy    <= 1'b1;
              r_state  <= S_DONE;
            end else if (r_cnt == C_FULL) begin
              r_result <= w_quo_signed;
              r_exc    <= r_div_ovf;
              r_rdy    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_rem <= w_rem_next;
              r_quo <= w_quo_next;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule
